sha256_nonce_sched: RTL

- Sequences the SHA-256 second-block core across a nonce range for one mining job.
- Accepts a job (midstate, 96-bit header tail, nonce range, target) and forms block2 per nonce.
- Issues each block2 to the core and compares each hash against the target.
- Reports the first winning nonce, or exhaustion of the range. Sits between the job loader and the single sha256 core.

---
 rtl/sha256_sched_pkg.sv | 25 ++
 rtl/sha256_target_cmp.sv | 10 +
 rtl/sha256_nonce_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 nonce scheduler.
// Block2 padding assumes an 80-byte (640-bit) header.
package sha256_sched_pkg;

    localparam int TAIL_W = 96;

    localparam logic [0:383] PAD_640 = {8'h80, 312'h0, 64'h280};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_REPORT
    } state_t;

    typedef struct packed {
        logic [0:255]        midstate;
        logic [0:TAIL_W-1]   tail;
        logic [31:0]         nonce_start;
        logic [31:0]         nonce_end;
        logic [0:255]        target;
    } job_t;

endpackage

// File: rtl/sha256_target_cmp.sv
// Combinational hash <= target check; bit [0] of both operands is the MSB.
module sha256_target_cmp (
    input  logic [0:255] hash,
    input  logic [0:255] target,
    output logic         hit
);

    assign hit = (hash <= target);

endmodule

// File: rtl/sha256_nonce_sched.sv
// Walks one job's nonce range through a single SHA-256 second-block core.
// Define SHA256_SCHED_PERF_EN to add the perf_hashes / perf_busy outputs.
module sha256_nonce_sched
    import sha256_sched_pkg::*;
#(
    parameter int NONCE_W     = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [0:255]       job_midstate,
    input  logic [0:TAIL_W-1]  job_tail,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic [0:255]       job_target,
    output logic               core_start,
    output logic [0:255]       core_midstate,
    output logic [0:511]       core_block2,
    input  logic               core_done,
    input  logic [0:255]       core_hash,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic               res_error,
    output logic [NONCE_W-1:0] res_nonce
`ifdef SHA256_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_hashes,
    output logic               perf_busy
`endif
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    state_t state, state_nx;
    job_t job;
    logic [0:255] hash_q;
    logic [WD_W-1:0] wdog;
    logic [NONCE_W-1:0] nonce_nx;
    logic hit, last;

    sha256_target_cmp u_cmp (
        .hash   (hash_q),
        .target (job.target),
        .hit    (hit)
    );

    // job.nonce_start doubles as the running nonce once the job is loaded
    assign nonce_nx = job.nonce_start + 1'b1;
    assign last = (job.nonce_start == job.nonce_end);

    assign job_ready = (state == S_IDLE) && !rst;
    assign core_start = (state == S_ISSUE);
    assign res_valid = (state == S_REPORT);
    assign core_midstate = job.midstate;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (job_valid) state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT: begin
                if (core_done)
                    state_nx = S_CHECK;
                else if (wdog == WD_LAST)
                    state_nx = S_REPORT;
            end
            S_CHECK:  state_nx = (hit || last) ? S_REPORT : S_ISSUE;
            S_REPORT: if (res_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            job         <= '0;
            hash_q      <= '0;
            wdog        <= '0;
            core_block2 <= '0;
            res_found   <= 1'b0;
            res_error   <= 1'b0;
            res_nonce   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        job <= '{midstate:    job_midstate,
                                 tail:        job_tail,
                                 nonce_start: job_nonce_start,
                                 nonce_end:   job_nonce_end,
                                 target:      job_target};
                        core_block2 <= {job_tail, job_nonce_start,
                                        PAD_640};
                    end
                end
                S_ISSUE: wdog <= '0;
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (core_done) begin
                        hash_q <= core_hash;
                    end else if (wdog == WD_LAST) begin
                        res_error <= 1'b1;
                        res_found <= 1'b0;
                        res_nonce <= job.nonce_start;
                    end
                end
                S_CHECK: begin
                    if (hit || last) begin
                        res_found <= hit;
                        res_nonce <= job.nonce_start;
                    end else begin
                        job.nonce_start <= nonce_nx;
                        core_block2 <= {job.tail, nonce_nx, PAD_640};
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_found <= 1'b0;
                        res_error <= 1'b0;
                        res_nonce <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_SCHED_PERF_EN
    assign perf_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            perf_hashes <= '0;
        else if (state == S_IDLE && job_valid)
            perf_hashes <= '0;
        else if (state == S_WAIT && core_done && perf_hashes != '1)
            perf_hashes <= perf_hashes + 1'b1;
    end
`else
`endif

endmodule
